taint_arbiter: RTL and testbench
================================

// Module: taint_arbiter
// PURPOSE
//  Shares one combinational taint checker (existing module `taint`) among NREQ ALU-operand requesters.
//  Round-robin arbitration; valid/ready on both sides; one registered result per cycle.
//  Keeps a saturating count of tainted operand pairs and a sticky alarm for the monitor.
//  Sits between the per-lane operand taps and the taint monitor/response logic.
// PARAMETERS
//  NREQ   4   number of requesters, 2..8
//  CNT_W  16  width of the tainted-event counter
// PORTS
//  clk          in   1          single clock, rising edge
//  rst          in   1          synchronous, active-high reset
//  req_valid    in   NREQ       requester k presents an operand dword
//  req_data     in   64*NREQ    dword k at [64k+63:64k]; hi/lo words are the two ALU operands
//  req_ready    out  NREQ       one-hot or zero; dword k accepted when valid[k]&ready[k]
//  out_valid    out  1          registered result available
//  out_ready    in   1          consumer accepts result
//  out_data     out  64         checker output for the accepted dword
//  out_tag      out  clog2(NREQ) index of the requester that produced out_data
//  out_tainted  out  1          result was tainted
//  taint_cnt    out  CNT_W      saturating count of tainted accepts
//  taint_alarm  out  1          sticky; set on first tainted accept
//  cnt_clr      in   1          clears taint_cnt and taint_alarm
// BEHAVIOUR
//  Reset: req_ready=0, out_valid=0, out_data=0, out_tag=0, out_tainted=0, taint_cnt=0, taint_alarm=0, rr pointer=0.
//  Taint rule: tainted = d[63] | d[31].
//   - Tainted: out_data = d | 64'h8000_0000_8000_0000.
//   - Clean: out_data = d.
//  Arbitration: search req_valid from pointer p upward (mod NREQ); first hit k is granted.
//   - Pointer advances to (k+1)%NREQ only on an accept. An unaccepted grant does not move p.
//  Ready: req_ready[k] = grant[k] & (~out_valid | out_ready). At most one accept per cycle.
//   - req_ready is zero when no valid is asserted.
//  Latency: accept in cycle t -> out_valid=1 with data/tag/tainted in t+1.
//   - Back-to-back throughput: 1 per cycle while out_ready=1.
//  Output hold: while out_valid & ~out_ready, out_* are stable and no new accept occurs.
//  Simultaneous out_ready & new accept: the register reloads, out_valid stays 1 with no bubble.
//  out_ready with no new accept: out_valid -> 0 next cycle.
//  Counter: +1 per tainted accept; it saturates at all-ones and does not wrap.
//   - taint_alarm sets on the same edge as the increment.
//  cnt_clr wins over a concurrent tainted accept: count=0, alarm=0, and that event is not counted.
//   - The result itself is still delivered.
//  Reset mid-operation: any pending result is discarded (out_valid=0) and the pointer returns to 0.
//  Requester protocol: valid must not drop and data must not change until accepted. The block does not check this.
//  States: EMPTY (out_valid=0) and FULL (out_valid=1).
//   - EMPTY->FULL on accept.
//   - FULL->EMPTY on out_ready & no accept.
//   - FULL->FULL on hold, or on out_ready & accept.
// STRUCTURE
//  Shared package taint_pkg:
//   - TAINT_MASK = 64'h8000_0000_8000_0000.
//   - TAINT_HI_BIT = 63, TAINT_LO_BIT = 31.
//   - The result struct type {data, tag, tainted}.
//  Sub-module rr_arbiter:
//   - Params: NREQ.
//   - Ports: clk, rst, req, advance -> grant (one-hot).
//   - Holds the pointer and is reusable by other monitors.
//  The `taint` checker is instantiated unchanged on the muxed granted dword.
//  The tainted flag is recomputed from the granted dword's bits 63 and 31.
// TESTING
//  1. Reset then idle: all outputs 0 for 10 cycles with req_valid=0.
//  2. Single req0 with data=64'h0000_0001_0000_0002: next cycle out_data equal, tainted=0, tag=0, cnt=0.
//  3. req1 with data=64'h8000_0000_0000_0005: out_data=64'h8000_0000_8000_0005, tainted=1, cnt=1, alarm=1.
//  4. All 4 valid continuously with out_ready=1: tags 0,1,2,3,0 on consecutive cycles, no bubbles.
//  5. out_ready=0 for 5 cycles with FULL: out_* stable, req_ready=0. Release -> queued grant proceeds, rr order kept.
//  6. CNT_W=2: 5 tainted accepts -> cnt=3 (saturated). Assert cnt_clr with a tainted accept -> cnt=0, alarm=0, result still out.

Source files
------------

// File: rtl/taint_pkg.sv
// Shared constants and types for the taint checking path.
// The result register layout is shared by the arbiter and the downstream monitor.
package taint_pkg;

    localparam logic [63:0] TAINT_MASK   = 64'h8000_0000_8000_0000;
    localparam int          TAINT_HI_BIT = 63;
    localparam int          TAINT_LO_BIT = 31;

    // Widest tag needed for the supported requester count (up to 8).
    localparam int TAG_W_MAX = 3;

    typedef struct packed {
        logic [63:0]          data;
        logic [TAG_W_MAX-1:0] tag;
        logic                 tainted;
    } result_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from a pointer that moves
// past the winner only when the grant is actually taken.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic [PW-1:0] idx;
    logic          found;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        grant = '0;
        gidx  = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = PW'((int'(ptr) + i) % NREQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gidx       = idx;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
        end
    end

endmodule

// File: rtl/taint.sv
// Combinational taint checker: marks both operand sign bits when either operand is tainted.
module taint
    import taint_pkg::*;
(
    input  logic [63:0] d,
    output logic [63:0] q
);

    assign q = (d[TAINT_HI_BIT] | d[TAINT_LO_BIT]) ? (d | TAINT_MASK) : d;

endmodule

// File: rtl/taint_arbiter.sv
// Shares one taint checker among NREQ operand requesters with round-robin
// arbitration, a one-deep registered result, and a saturating taint counter/alarm.
module taint_arbiter
    import taint_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [64*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              out_data,
    output logic [$clog2(NREQ)-1:0]  out_tag,
    output logic                     out_tainted,
    output logic [CNT_W-1:0]         taint_cnt,
    output logic                     taint_alarm,
    input  logic                     cnt_clr
);

    localparam int TW = $clog2(NREQ);

    out_state_e      state;
    result_t         res;
    logic [NREQ-1:0] grant;
    logic            can_accept;
    logic            accept;
    logic [63:0]     gdata;
    logic [63:0]     chk_data;
    logic [TW-1:0]   gtag;
    logic            gtainted;
    logic            tag_unused;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (accept),
        .grant   (grant)
    );

    always_comb begin
        gdata = '0;
        gtag  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant[k]) begin
                gdata = req_data[64*k +: 64];
                gtag  = TW'(k);
            end
        end
    end

    taint u_taint (
        .d (gdata),
        .q (chk_data)
    );

    assign gtainted = gdata[TAINT_HI_BIT] | gdata[TAINT_LO_BIT];

    // The result slot frees up in the same cycle the consumer takes it.
    assign can_accept = ~rst & ((state == EMPTY) | out_ready);
    assign req_ready  = grant & {NREQ{can_accept}};
    assign accept     = |(req_valid & req_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            res         <= '0;
            taint_cnt   <= '0;
            taint_alarm <= 1'b0;
        end else begin
            case (state)
                EMPTY:   if (accept) state <= FULL;
                FULL:    if (out_ready && !accept) state <= EMPTY;
                default: state <= EMPTY;
            endcase

            if (accept) begin
                res <= '{data: chk_data, tag: TAG_W_MAX'(gtag), tainted: gtainted};
            end

            // A clear in the same cycle as a tainted accept drops that event.
            if (cnt_clr) begin
                taint_cnt   <= '0;
                taint_alarm <= 1'b0;
            end else if (accept && gtainted) begin
                taint_alarm <= 1'b1;
                if (taint_cnt != '1) taint_cnt <= taint_cnt + 1'b1;
            end
        end
    end

    assign out_valid   = (state == FULL);
    assign out_data    = res.data;
    assign out_tag     = res.tag[TW-1:0];
    assign out_tainted = res.tainted;
    assign tag_unused  = ^res.tag;

endmodule

// File: tb/tb_taint_arbiter.sv
// Scoreboard bench for taint_arbiter: expected results are queued at drive time
// and compared whenever the DUT hands a result to the consumer.
module tb_taint_arbiter;

    localparam int NREQ  = 4;
    localparam int CNT_W = 2;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  tag;
        logic        tainted;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [64*NREQ-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [63:0]        out_data;
    logic [1:0]         out_tag;
    logic               out_tainted;
    logic [CNT_W-1:0]   taint_cnt;
    logic               taint_alarm;
    logic               cnt_clr = 1'b0;

    logic [63:0] lane_data [NREQ];

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NREQ; k++) req_data[64*k +: 64] = lane_data[k];
    end

    taint_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_tag     (out_tag),
        .out_tainted (out_tainted),
        .taint_cnt   (taint_cnt),
        .taint_alarm (taint_alarm),
        .cnt_clr     (cnt_clr)
    );

    // Every handshake on the output side pops and checks one expected result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_result: got data=%h tag=%0d tainted=%0b, required no output",
                         out_data, out_tag, out_tainted);
            end else begin
                mon_e = exp_q.pop_front();
                if ({out_data, out_tag, out_tainted} !== {mon_e.data, mon_e.tag, mon_e.tainted}) begin
                    miscompares++;
                    $display("FAIL result: got data=%h tag=%0d tainted=%0b, required data=%h tag=%0d tainted=%0b",
                             out_data, out_tag, out_tainted, mon_e.data, mon_e.tag, mon_e.tainted);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] d, input logic [1:0] tag);
        exp_t e;
        e.tainted = d[63] | d[31];
        e.data    = e.tainted ? (d | 64'h8000_0000_8000_0000) : d;
        e.tag     = tag;
        exp_q.push_back(e);
    endtask

    task automatic expect_bit(input string name, input logic got, input logic req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %0b, required %0b", name, got, req);
        end
    endtask

    task automatic expect_cnt(input string name, input int req_cnt, input logic req_alarm);
        vectors++;
        if (taint_cnt !== CNT_W'(req_cnt) || taint_alarm !== req_alarm) begin
            miscompares++;
            $display("FAIL %s: got cnt=%0d alarm=%0b, required cnt=%0d alarm=%0b",
                     name, taint_cnt, taint_alarm, req_cnt, req_alarm);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < NREQ; k++) lane_data[k] = '0;
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if ({req_ready, out_valid, out_data, out_tag, out_tainted, taint_cnt, taint_alarm} !== '0) begin
                miscompares++;
                $display("FAIL reset_idle: cycle %0d got ready=%b valid=%b data=%h tag=%0d tainted=%b cnt=%0d alarm=%b, required all zero",
                         i, req_ready, out_valid, out_data, out_tag, out_tainted, taint_cnt, taint_alarm);
            end
            tick();
        end
    endtask

    task automatic test_single_clean();
        out_ready    = 1'b1;
        lane_data[0] = 64'h0000_0001_0000_0002;
        push(lane_data[0], 2'd0);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        @(negedge clk);
        expect_bit("single_valid", out_valid, 1'b1);
        expect_cnt("single_cnt", 0, 1'b0);
        tick();
    endtask

    task automatic test_single_tainted();
        lane_data[1] = 64'h8000_0000_0000_0005;
        push(lane_data[1], 2'd1);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        @(negedge clk);
        vectors++;
        if (out_data !== 64'h8000_0000_8000_0005 || out_tainted !== 1'b1) begin
            miscompares++;
            $display("FAIL tainted_data: got data=%h tainted=%b, required data=8000000080000005 tainted=1",
                     out_data, out_tainted);
        end
        expect_cnt("tainted_cnt", 1, 1'b1);
        tick();
    endtask

    task automatic test_reset_midop();
        out_ready    = 1'b0;
        lane_data[2] = 64'h0000_0022_0000_0022;
        req_valid    = 4'b0100;
        tick();
        req_valid = '0;
        @(negedge clk);
        expect_bit("midop_pending", out_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        expect_bit("midop_discard", out_valid, 1'b0);
        expect_cnt("midop_cnt", 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [1:0] order [5];
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int k = 0; k < NREQ; k++) lane_data[k] = {32'h0000_0100 + 32'(k), 32'(k)};
        for (int i = 0; i < 5; i++) push(lane_data[order[i]], order[i]);
        out_ready = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 4) req_valid = '0;
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_tag !== order[i]) begin
                miscompares++;
                $display("FAIL back_to_back: beat %0d got valid=%b tag=%0d, required valid=1 tag=%0d",
                         i, out_valid, out_tag, order[i]);
            end
        end
        tick();
        @(negedge clk);
        expect_bit("b2b_drain", out_valid, 1'b0);
    endtask

    task automatic test_hold();
        lane_data[1] = 64'h0000_0000_1111_0001;
        lane_data[2] = 64'h0000_0000_2222_0002;
        push(lane_data[1], 2'd1);
        push(lane_data[2], 2'd2);
        out_ready = 1'b0;
        req_valid = 4'b0110;
        tick();
        req_valid = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_data !== lane_data[1] || out_tag !== 2'd1 || req_ready !== 4'b0000) begin
                miscompares++;
                $display("FAIL hold: cycle %0d got valid=%b data=%h tag=%0d ready=%b, required valid=1 data=%h tag=1 ready=0000",
                         i, out_valid, out_data, out_tag, req_ready, lane_data[1]);
            end
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL hold_release_ready: got %b, required 0100", req_ready);
        end
        tick();
        req_valid = '0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_tag !== 2'd2) begin
            miscompares++;
            $display("FAIL hold_no_bubble: got valid=%b tag=%0d, required valid=1 tag=2", out_valid, out_tag);
        end
        tick();
        @(negedge clk);
        expect_bit("hold_drain", out_valid, 1'b0);
    endtask

    task automatic test_saturate_clear();
        lane_data[3] = 64'h0000_0000_8000_0007;
        for (int i = 0; i < 5; i++) push(lane_data[3], 2'd3);
        out_ready = 1'b1;
        req_valid = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 4) req_valid = '0;
            @(negedge clk);
            expect_cnt("saturate", (i + 1 > 3) ? 3 : i + 1, 1'b1);
        end
        tick();
        lane_data[0] = 64'h8000_0000_0000_00aa;
        push(lane_data[0], 2'd0);
        req_valid = 4'b0001;
        cnt_clr   = 1'b1;
        tick();
        req_valid = '0;
        cnt_clr   = 1'b0;
        @(negedge clk);
        expect_cnt("clr_wins", 0, 1'b0);
        expect_bit("clr_result_valid", out_valid, 1'b1);
        expect_bit("clr_result_tainted", out_tainted, 1'b1);
        tick();
        @(negedge clk);
        expect_cnt("clr_after", 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_clean();
        test_single_tainted();
        test_reset_midop();
        test_back_to_back();
        test_hold();
        test_saturate_clear();
        repeat (2) tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d results outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
